key_freq_gen: RTL and testbench

Parametrised successor to the piano key-to-frequency block. It synchronises and debounces an arbitrary number of raw key inputs. For each key it computes a registered half-period count, base period divided by 2×scale, using one shared sequential divider, so there is no combinational divide. It sits between the keyboard pins and the tone generators/screen control, and reports each output update with a one-cycle strobe.

---
 rtl/key_freq_gen.sv | 196 +++++++++++++++++++
 tb/tb_key_freq_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_freq_gen.sv
// Key synchroniser/debouncer with per-key half-period words computed
// by one shared restoring divider, one word update at a time.
module key_freq_gen #(
    parameter int NUM_KEYS        = 13,
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_KEYS-1:0]        keyboard,
    input  logic [2:0]                 scale,
    output logic [WIDTH-1:0]           note_half_period [NUM_KEYS],
    output logic [NUM_KEYS-1:0]        key_state,
    output logic                       update_strobe,
    output logic [(NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1)-1:0] update_key,
    output logic                       busy
);
    localparam int KW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int KW1 = KW + 1;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW  = $clog2(WIDTH + 1);
    localparam int DW  = 4;

    typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, WRITE} state_e;

    localparam logic [31:0] BASE [13] = '{
        32'd191113, 32'd180387, 32'd170262, 32'd160706,
        32'd151686, 32'd143173, 32'd135137, 32'd127553,
        32'd120394, 32'd113636, 32'd107258, 32'd101238,
        32'd95556
    };

    // Each further group of 13 keys sits one octave higher.
    function automatic logic [WIDTH-1:0] base_of(input int k);
        logic [31:0] t;
        t = BASE[k % 13] >> (k / 13);
        return WIDTH'(t);
    endfunction

    state_e                state_q, state_d;
    logic [NUM_KEYS-1:0]   sync1_q, sync2_q;
    logic [NUM_KEYS-1:0]   ks_q, ks_d;
    logic [CW-1:0]         cnt_q [NUM_KEYS];
    logic [CW-1:0]         cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]   dirty_q, dirty_d;
    logic [2:0]            scale_q;
    logic [KW-1:0]         ptr_q, ptr_d;
    logic [KW-1:0]         key_q, key_d;
    logic [WIDTH-1:0]      quo_q, quo_d;
    logic [DW-1:0]         rem_q, rem_d;
    logic [DW-1:0]         div_q, div_d;
    logic [SW-1:0]         step_q, step_d;
    logic                  strobe_q, strobe_d;
    logic [KW-1:0]         ukey_q, ukey_d;
    logic [WIDTH-1:0]      note_q [NUM_KEYS];
    logic [WIDTH-1:0]      note_d [NUM_KEYS];
    logic [WIDTH-1:0]      base_tbl [NUM_KEYS];
    logic [KW-1:0]         sel;
    logic [KW1-1:0]        j;
    logic [DW:0]           trial;
    logic                  ge;
    logic                  found;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_base
        assign base_tbl[g] = base_of(g);
    end

    always_comb begin
        ks_d = ks_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != ks_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    ks_d[i] = ~ks_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // First dirty key at or after the round-robin pointer.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            j = {1'b0, ptr_q} + KW1'(i);
            if (j >= KW1'(NUM_KEYS)) begin
                j = j - KW1'(NUM_KEYS);
            end
            if (!found && dirty_q[j[KW-1:0]]) begin
                found = 1'b1;
                sel   = j[KW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (|dirty_q) state_d = LOAD;
            LOAD:   state_d = (ks_q[key_q] && scale_q != '0) ? DIVIDE : WRITE;
            DIVIDE: if (step_q == SW'(WIDTH - 1)) state_d = WRITE;
            WRITE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign ge    = trial >= {1'b0, div_q};

    always_comb begin
        key_d    = key_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        step_d   = step_q;
        ptr_d    = ptr_q;
        ukey_d   = ukey_q;
        strobe_d = 1'b0;
        note_d   = note_q;
        dirty_d  = dirty_q;
        unique case (state_q)
            IDLE: key_d = sel;
            LOAD: begin
                dirty_d[key_q] = 1'b0;
                rem_d  = '0;
                step_d = '0;
                div_d  = {scale_q, 1'b0};
                quo_d  = (ks_q[key_q] && scale_q != '0) ? base_tbl[key_q] : '0;
            end
            DIVIDE: begin
                rem_d  = ge ? DW'(trial - {1'b0, div_q}) : trial[DW-1:0];
                quo_d  = {quo_q[WIDTH-2:0], ge};
                step_d = step_q + 1'b1;
            end
            WRITE: begin
                note_d[key_q] = quo_q;
                strobe_d = 1'b1;
                ukey_d   = key_q;
                ptr_d    = (key_q == KW'(NUM_KEYS - 1)) ? '0 : key_q + 1'b1;
            end
            default: ;
        endcase
        // A new change always wins over the LOAD clear.
        dirty_d = dirty_d | (ks_d ^ ks_q) | {NUM_KEYS{scale != scale_q}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            ks_q     <= '0;
            dirty_q  <= '0;
            scale_q  <= '0;
            ptr_q    <= '0;
            key_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            step_q   <= '0;
            strobe_q <= 1'b0;
            ukey_q   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i]  <= '0;
                note_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sync1_q  <= keyboard;
            sync2_q  <= sync1_q;
            ks_q     <= ks_d;
            dirty_q  <= dirty_d;
            scale_q  <= scale;
            ptr_q    <= ptr_d;
            key_q    <= key_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            step_q   <= step_d;
            strobe_q <= strobe_d;
            ukey_q   <= ukey_d;
            cnt_q    <= cnt_d;
            note_q   <= note_d;
        end
    end

    assign note_half_period = note_q;
    assign key_state        = ks_q;
    assign update_strobe    = strobe_q;
    assign update_key       = ukey_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_key_freq_gen.sv
// Scoreboard bench for key_freq_gen: 13-key and 26-key instances
// checked against an arithmetic reference of the key table.
module tb_key_freq_gen;
    localparam int N   = 13;
    localparam int NW  = 26;
    localparam int W   = 32;
    localparam int DEB = 4;
    localparam int LAT = W + 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [N-1:0]  kb = '0;
    logic [2:0]    sc = '0;
    logic [W-1:0]  hp [N];
    logic [N-1:0]  ks;
    logic          strobe;
    logic [3:0]    ukey;
    logic          busy;

    logic [NW-1:0] kbw = '0;
    logic [2:0]    scw = '0;
    logic [W-1:0]  hpw [NW];
    logic [NW-1:0] ksw;
    logic          strobew;
    logic [4:0]    ukeyw;
    logic          busyw;

    typedef struct {
        int     key;
        longint val;
    } exp_t;

    exp_t   q[$];
    exp_t   qw[$];
    longint words [N];
    longint wordsw [NW];
    bit     pressed [N];
    int     cur_sc = 0;
    int     ptr = 0;
    int     ptrw = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    key_freq_gen #(.NUM_KEYS(N), .WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset_n(reset_n), .keyboard(kb), .scale(sc),
        .note_half_period(hp), .key_state(ks), .update_strobe(strobe),
        .update_key(ukey), .busy(busy)
    );

    key_freq_gen #(.NUM_KEYS(NW), .WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dutw (
        .clk(clk), .reset_n(reset_n), .keyboard(kbw), .scale(scw),
        .note_half_period(hpw), .key_state(ksw), .update_strobe(strobew),
        .update_key(ukeyw), .busy(busyw)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic longint ref_hp(int k, int s, bit p);
        longint tab [13];
        longint b;
        tab = '{191113, 180387, 170262, 160706, 151686, 143173, 135137,
                127553, 120394, 113636, 107258, 101238, 95556};
        if (!p || s == 0) return 0;
        b = tab[k % 13] >> (k / 13);
        return b / (2 * s);
    endfunction

    task automatic check(string nm, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(int k, longint v);
        exp_t e;
        e.key = k;
        e.val = v;
        q.push_back(e);
        ptr = (k + 1) % N;
    endtask

    task automatic push_w(int k, longint v);
        exp_t e;
        e.key = k;
        e.val = v;
        qw.push_back(e);
        ptrw = (k + 1) % NW;
    endtask

    // Dirty keys are served in circular order from the pointer.
    task automatic push_mask(logic [N-1:0] m);
        int start;
        int k;
        start = ptr;
        for (int i = 0; i < N; i++) begin
            k = (start + i) % N;
            if (m[k]) push(k, ref_hp(k, cur_sc, pressed[k]));
        end
    endtask

    function automatic logic [N-1:0] model_ks();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = pressed[i];
        return m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   mism;
        if (reset_n && strobe) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: key %0d value %0d, none expected",
                         ukey, hp[ukey]);
            end else begin
                e = q.pop_front();
                check("update_key", ukey, e.key);
                check("update_value", hp[e.key], e.val);
                words[e.key] = e.val;
                mism = 0;
                for (int i = 0; i < N; i++) begin
                    if (longint'(hp[i]) != words[i]) mism++;
                end
                check("words_mismatched", mism, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && strobew) begin
            if (qw.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe_wide: key %0d, none expected", ukeyw);
            end else begin
                e = qw.pop_front();
                check("wide_update_key", ukeyw, e.key);
                check("wide_update_value", hpw[e.key], e.val);
                wordsw[e.key] = e.val;
            end
        end
    end

    task automatic wait_quiet(bit wide);
        int n;
        n = 0;
        while (((wide ? qw.size() : q.size()) != 0 || (wide ? busyw : busy))
               && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(wide ? "wide_pending_writes" : "pending_writes",
              wide ? qw.size() : q.size(), 0);
        if (wide) qw.delete();
        else q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic toggle(int k);
        @(negedge clk);
        kb[k] = ~kb[k];
        pressed[k] = kb[k];
        push(k, ref_hp(k, cur_sc, pressed[k]));
        wait_quiet(0);
        check("key_state", ks, model_ks());
    endtask

    task automatic set_scale(int s);
        @(negedge clk);
        sc = 3'(s);
        if (s != cur_sc) begin
            cur_sc = s;
            push_mask('1);
        end
        wait_quiet(0);
    endtask

    task automatic edges_until_strobe(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!strobe && n < 200);
    endtask

    task automatic edges_until_ks(int k, bit lvl, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ks[k] != lvl && n < 200);
    endtask

    initial begin
        int n;
        int k;
        int r;
        int nz;
        bit seen;

        for (int i = 0; i < N; i++) begin
            words[i] = 0;
            pressed[i] = 1'b0;
        end
        for (int i = 0; i < NW; i++) wordsw[i] = 0;

        repeat (3) @(negedge clk);
        nz = 0;
        for (int i = 0; i < N; i++) if (hp[i] != '0) nz++;
        check("reset_words_nonzero", nz, 0);
        check("reset_key_state", ks, 0);
        check("reset_strobe", strobe, 0);
        check("reset_busy", busy, 0);
        check("reset_update_key", ukey, 0);
        reset_n = 1'b1;

        set_scale(1);

        @(negedge clk);
        kb[0] = 1'b1;
        pressed[0] = 1'b1;
        push(0, ref_hp(0, 1, 1));
        edges_until_ks(0, 1'b1, n);
        check("press_debounce_edges", n, DEB + 2);
        edges_until_strobe(n);
        check("press_latency", n, LAT);
        check("press_value_key0", hp[0], 95556);
        wait_quiet(0);

        @(negedge clk);
        kb[0] = 1'b0;
        pressed[0] = 1'b0;
        push(0, 0);
        edges_until_ks(0, 1'b0, n);
        check("release_debounce_edges", n, DEB + 2);
        edges_until_strobe(n);
        check("release_latency", n, 3);
        wait_quiet(0);

        @(negedge clk);
        kb[5] = 1'b1;
        repeat (3) @(negedge clk);
        kb[5] = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= ks[5];
        end
        check("glitch_key_state_seen", seen, 0);
        check("glitch_word", hp[5], 0);

        @(negedge clk);
        kb[2] = 1'b1;
        kb[7] = 1'b1;
        pressed[2] = 1'b1;
        pressed[7] = 1'b1;
        push_mask(N'(13'h0084));
        edges_until_strobe(n);
        check("contention_first_latency", n, DEB + 2 + LAT);
        edges_until_strobe(n);
        check("contention_gap", n, LAT);
        wait_quiet(0);

        set_scale(2);
        toggle(2);
        toggle(7);
        toggle(9);
        check("key9_scale2", hp[9], 28409);
        toggle(9);

        set_scale(3);
        toggle(12);
        check("key12_scale3", hp[12], 15926);
        set_scale(0);
        check("key12_muted", hp[12], 0);
        toggle(12);

        set_scale(1);
        @(negedge clk);
        kb[3] = 1'b1;
        pressed[3] = 1'b1;
        push(3, ref_hp(3, 1, 1));
        edges_until_ks(3, 1'b1, n);
        repeat (10) @(negedge clk);
        check("middiv_busy", busy, 1);
        sc = 3'd2;
        cur_sc = 2;
        push_mask('1);
        wait_quiet(0);
        check("middiv_rewrite_key3", hp[3], 40176);

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 3);
            if (r == 0) set_scale($urandom_range(0, 7));
            else toggle($urandom_range(0, N - 1));
        end

        set_scale(5);
        k = -1;
        for (int i = N - 1; i >= 0; i--) if (!pressed[i]) k = i;
        if (k < 0) begin
            toggle(0);
            k = 0;
        end
        @(negedge clk);
        kb[k] = 1'b1;
        edges_until_ks(k, 1'b1, n);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        kb = '0;
        sc = '0;
        cur_sc = 0;
        ptr = 0;
        q.delete();
        for (int i = 0; i < N; i++) begin
            words[i] = 0;
            pressed[i] = 1'b0;
        end
        #2;
        nz = 0;
        for (int i = 0; i < N; i++) if (hp[i] != '0) nz++;
        check("abort_words_nonzero", nz, 0);
        check("abort_busy", busy, 0);
        check("abort_strobe", strobe, 0);
        check("abort_key_state", ks, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen |= busy;
        end
        check("post_reset_busy_seen", seen, 0);

        @(negedge clk);
        scw = 3'd1;
        for (int i = 0; i < NW; i++) push_w(i, 0);
        wait_quiet(1);
        @(negedge clk);
        kbw[13] = 1'b1;
        push_w(13, ref_hp(13, 1, 1));
        wait_quiet(1);
        check("wide_key13", hpw[13], 47778);
        @(negedge clk);
        kbw[25] = 1'b1;
        push_w(25, ref_hp(25, 1, 1));
        edges_until_ks(0, 1'b1, n);
        wait_quiet(1);
        check("wide_key25", hpw[25], 23889);
        check("wide_last_update_key", ukeyw, 25);
        check("wide_key13_held", hpw[13], 47778);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
